// File: rtl/design07_pkg.sv
// design07_pkg: shared width, FSM state encoding and operand/signature helpers
// for the mkDesign_07 stimulus sequencer.
package design07_pkg;
  localparam int W = 11;
  typedef enum logic [2:0] {IDLE, S_START, S_RESULT, S_CHECK, DONE} state_e;
  function automatic logic [W-1:0] rotl1(input logic [W-1:0] x);
    return {x[W-2:0], x[W-1]};
  endfunction
  function automatic logic [W-1:0] op_sta(input logic [15:0] i, input logic [W-1:0] seed);
    return seed + i[W-1:0];
  endfunction
  function automatic logic [W-1:0] op_stb(input logic [15:0] i, input logic [W-1:0] mask);
    return i[W-1:0] ^ mask;
  endfunction
  function automatic logic [W-1:0] op_stc(input logic [W-1:0] sta);
    return ~sta;
  endfunction
  function automatic logic [W-1:0] op_std(input logic [W-1:0] sta, input logic [W-1:0] stb);
    return sta + stb;
  endfunction
endpackage

// File: rtl/design07_sig_acc.sv
// design07_sig_acc: W-bit rotating XOR signature register.
// Ports: CLK/RST_N clock and async active-low reset; clr zeroes the signature;
// en_a/a and en_b/b fold a value in as rotl1(sig)^value (a has priority); sig is the current value.
module design07_sig_acc
  import design07_pkg::*;
(
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         clr,
  input  logic         en_a,
  input  logic [W-1:0] a,
  input  logic         en_b,
  input  logic [W-1:0] b,
  output logic [W-1:0] sig
);
  logic [W-1:0] sig_q, sig_d;
  always_comb sig_d = clr ? '0 : en_a ? rotl1(sig_q) ^ a : en_b ? rotl1(sig_q) ^ b : sig_q;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) sig_q <= '0;
    else sig_q <= sig_d;
  assign sig = sig_q;
endmodule

// File: rtl/design07_stim_seq.sv
// design07_stim_seq: stimulus sequencer driving mkDesign_07 start/result/check methods.
// Ports: CLK, RST_N (async active-low); go starts a run from IDLE/DONE;
// start_sta_1/start_stb_1/EN_start/RDY_start, result_stc_1/result/RDY_result,
// check_std_1/EN_check/check/RDY_check are the method handshakes;
// busy/done/txn_cnt/sig/timeout report progress and the running signature.
// Optional: define STIM_TIMEOUT_EN to enable the stall watchdog.
module design07_stim_seq
  import design07_pkg::*;
#(
  parameter int           NUM_TXN = 16,
  parameter logic [W-1:0] SEED_A  = 11'h001,
  parameter logic [W-1:0] MASK_B  = 11'h555,
  parameter int           TIMEOUT = 64
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         go,
  output logic [W-1:0] start_sta_1,
  output logic [W-1:0] start_stb_1,
  output logic         EN_start,
  input  logic         RDY_start,
  output logic [W-1:0] result_stc_1,
  input  logic [W-1:0] result,
  input  logic         RDY_result,
  output logic [W-1:0] check_std_1,
  output logic         EN_check,
  input  logic [W-1:0] check,
  input  logic         RDY_check,
  output logic         busy,
  output logic         done,
  output logic [15:0]  txn_cnt,
  output logic [W-1:0] sig,
  output logic         timeout
);
  state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d, idx;
  logic [W-1:0] sta_q, sta_d, stb_q, stb_d, stc_q, stc_d, std_q, std_d, nxt_sta, nxt_stb;
  logic start, res_ok, last, load, tmo_hit;
  assign start = (state_q == IDLE || state_q == DONE) && go;
  assign EN_start = (state_q == S_START) && RDY_start;
  assign EN_check = (state_q == S_CHECK) && RDY_check;
  assign res_ok = (state_q == S_RESULT) && RDY_result;
  assign last = (cnt_q + 16'd1) == 16'(NUM_TXN);
  // Operands for the next transaction are loaded as the FSM enters S_START.
  assign load = start || (EN_check && !last);
  always_comb begin
    idx = start ? 16'd0 : cnt_q + 16'd1;
    nxt_sta = op_sta(idx, SEED_A);
    nxt_stb = op_stb(idx, MASK_B);
    sta_d = load ? nxt_sta : sta_q;
    stb_d = load ? nxt_stb : stb_q;
    stc_d = load ? op_stc(nxt_sta) : stc_q;
    std_d = load ? op_std(nxt_sta, nxt_stb) : std_q;
    cnt_d = start ? 16'd0 : EN_check ? cnt_q + 16'd1 : cnt_q;
  end
  always_comb begin
    state_d = state_q;
    if (start) state_d = S_START;
    else if (tmo_hit) state_d = DONE;
    else if (EN_start) state_d = S_RESULT;
    else if (res_ok) state_d = S_CHECK;
    else if (EN_check) state_d = last ? DONE : S_START;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      cnt_q <= '0;
      sta_q <= '0;
      stb_q <= '0;
      stc_q <= '0;
      std_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sta_q <= sta_d;
      stb_q <= stb_d;
      stc_q <= stc_d;
      std_q <= std_d;
    end
`ifdef STIM_TIMEOUT_EN
  logic [15:0] wait_q, wait_d;
  logic tmo_q, tmo_d, stall;
  assign stall = (state_q == S_START && !RDY_start) || (state_q == S_RESULT && !RDY_result) ||
                 (state_q == S_CHECK && !RDY_check);
  // Trip on the edge where the TIMEOUT-th stalled cycle completes.
  assign tmo_hit = stall && wait_q == 16'(TIMEOUT - 1);
  always_comb begin
    wait_d = stall ? wait_q + 16'd1 : 16'd0;
    tmo_d = start ? 1'b0 : tmo_hit ? 1'b1 : tmo_q;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      wait_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      tmo_q <= tmo_d;
    end
  assign timeout = tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT == 0);
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif
  design07_sig_acc u_sig (
    .CLK  (CLK),
    .RST_N(RST_N),
    .clr  (start),
    .en_a (res_ok),
    .a    (result),
    .en_b (EN_check),
    .b    (check),
    .sig  (sig)
  );
  assign start_sta_1 = sta_q;
  assign start_stb_1 = stb_q;
  assign result_stc_1 = stc_q;
  assign check_std_1 = std_q;
  assign busy = state_q == S_START || state_q == S_RESULT || state_q == S_CHECK;
  assign done = state_q == DONE;
  assign txn_cnt = cnt_q;
endmodule

// File: tb/tb_design07_stim_seq.sv
// tb_design07_stim_seq: scoreboard bench for design07_stim_seq with a stub mkDesign_07.
module tb_design07_stim_seq;
  localparam int N = 4;
  logic CLK = 0, RST_N = 0, go = 0;
  logic RDY_start = 1, RDY_result = 1, RDY_check = 1, res_mode = 0;
  logic [10:0] sta, stb, stc, std, result, check, sig;
  logic EN_start, EN_check, busy, done, timeout, done_prev = 0;
  logic [15:0] txn_cnt;
  int n_checks = 0, n_errs = 0, cyc = 0, k = 0;
  typedef struct {int a; int b; int c; int d;} ops_t;
  ops_t opq[$];
  ops_t mon_o;
  int finq[$];

  assign result = res_mode ? sta * 11'd3 : 11'h7FF;
  assign check = res_mode ? std ^ 11'h2A5 : 11'h001;

  design07_stim_seq #(.NUM_TXN(N), .TIMEOUT(64)) dut (
    .CLK(CLK), .RST_N(RST_N), .go(go),
    .start_sta_1(sta), .start_stb_1(stb), .EN_start(EN_start), .RDY_start(RDY_start),
    .result_stc_1(stc), .result(result), .RDY_result(RDY_result),
    .check_std_1(std), .EN_check(EN_check), .check(check), .RDY_check(RDY_check),
    .busy(busy), .done(done), .txn_cnt(txn_cnt), .sig(sig), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int m_sta(int i); return (1 + i) & 'h7FF; endfunction
  function automatic int m_stb(int i); return (i ^ 'h555) & 'h7FF; endfunction
  function automatic int m_stc(int i); return ~m_sta(i) & 'h7FF; endfunction
  function automatic int m_std(int i); return (m_sta(i) + m_stb(i)) & 'h7FF; endfunction
  function automatic int m_rot(int x); return ((x << 1) | (x >> 10)) & 'h7FF; endfunction
  function automatic int m_res(int i, int mode); return mode != 0 ? (m_sta(i) * 3) & 'h7FF : 'h7FF; endfunction
  function automatic int m_chk(int i, int mode); return mode != 0 ? m_std(i) ^ 'h2A5 : 'h001; endfunction
  function automatic int exp_fin(int n, int mode);
    int s = 0;
    for (int i = 0; i < n; i++) begin
      s = m_rot(s) ^ m_res(i, mode);
      s = m_rot(s) ^ m_chk(i, mode);
    end
    return (n << 11) | s;
  endfunction

  task automatic push_op(input int i);
    opq.push_back('{m_sta(i), m_stb(i), m_stc(i), m_std(i)});
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic fire_go;
    go = 1;
    for (int i = 0; i < N; i++) push_op(i);
    finq.push_back(exp_fin(N, int'(res_mode)));
    step();
    go = 0;
  endtask

  task automatic wait_done(input string tag, input int exp);
    while (!done && cyc < 300) begin
      step();
      cyc++;
    end
    chk(tag, cyc, exp);
  endtask

  always @(negedge CLK) begin
    if (RST_N && EN_start) begin
      if (opq.size() == 0) chk("op_queue", opq.size(), 1);
      else begin
        mon_o = opq.pop_front();
        chk("sta", int'(sta), mon_o.a);
        chk("stb", int'(stb), mon_o.b);
        chk("stc", int'(stc), mon_o.c);
        chk("std", int'(std), mon_o.d);
      end
    end
    if (done && !done_prev) begin
      if (finq.size() == 0) chk("fin_queue", finq.size(), 1);
      else chk("fin_cnt_sig", int'({txn_cnt, sig}), finq.pop_front());
    end
    done_prev = done;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_en_start", int'(EN_start), 0);
    chk("rst_en_check", int'(EN_check), 0);
    chk("rst_cnt", int'(txn_cnt), 0);
    chk("rst_sig", int'(sig), 0);
    chk("rst_sta", int'(sta), 0);
    chk("rst_timeout", int'(timeout), 0);
    #9 RST_N = 1;
    step();
    // Constant stub returns: walk the first transaction cycle by cycle.
    fire_go();
    cyc = 0;
    chk("a_en_start", int'(EN_start), 1);
    chk("a_stc", int'(stc), 'h7FE);
    chk("a_std", int'(std), 'h556);
    step(); cyc++;
    chk("a_res_en", int'(EN_start), 0);
    chk("a_sig0", int'(sig), 0);
    step(); cyc++;
    chk("a_sig_res", int'(sig), 'h7FF);
    chk("a_en_check", int'(EN_check), 1);
    step(); cyc++;
    chk("a_sig_chk", int'(sig), 'h7FE);
    chk("a_cnt1", int'(txn_cnt), 1);
    chk("a_sta1", int'(sta), 'h002);
    chk("a_stb1", int'(stb), 'h554);
    wait_done("a_latency", 3 * N);
    chk("a_busy_done", int'(busy), 0);
    // RDY_start held low for 5 cycles, plus a go pulse while busy.
    step();
    res_mode = 1;
    RDY_start = 0;
    fire_go();
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      chk("b_stall_en", int'(EN_start), 0);
      step(); cyc++;
    end
    RDY_start = 1;
    #1;
    chk("b_fire", int'(EN_start), 1);
    go = 1;
    step(); cyc++;
    go = 0;
    chk("b_pulse_end", int'(EN_start), 0);
    wait_done("b_latency", 3 * N + 5);
    // go while in DONE restarts immediately.
    fire_go();
    cyc = 0;
    chk("c_done_low", int'(done), 0);
    chk("c_cnt_clr", int'(txn_cnt), 0);
    chk("c_busy", int'(busy), 1);
    wait_done("c_latency", 3 * N);
    // Async reset while stalled in S_RESULT of transaction 3.
    fire_go();
    k = 0;
    while (txn_cnt != 3 && k < 100) begin
      step(); k++;
    end
    chk("d_reach3", int'(txn_cnt), 3);
    RDY_result = 0;
    step();
    step();
    chk("d_busy", int'(busy), 1);
    chk("d_sta3", int'(sta), m_sta(3));
    #2 RST_N = 0;
    #1;
    chk("d_rst_busy", int'(busy), 0);
    chk("d_rst_en_start", int'(EN_start), 0);
    chk("d_rst_en_check", int'(EN_check), 0);
    chk("d_rst_sig", int'(sig), 0);
    chk("d_rst_cnt", int'(txn_cnt), 0);
    opq.delete();
    finq.delete();
    #2 RST_N = 1;
    RDY_result = 1;
    step();
    fire_go();
    cyc = 0;
    chk("d_restart_sta", int'(sta), 'h001);
    chk("d_restart_cnt", int'(txn_cnt), 0);
    wait_done("d_latency", 3 * N);
`ifdef STIM_TIMEOUT_EN
    RDY_check = 0;
    go = 1;
    push_op(0);
    finq.push_back(m_res(0, 1));
    step();
    go = 0;
    cyc = 0;
    wait_done("e_tmo_latency", 66);
    chk("e_timeout", int'(timeout), 1);
    chk("e_cnt_frozen", int'(txn_cnt), 0);
    RDY_check = 1;
    fire_go();
    cyc = 0;
    chk("e_timeout_clr", int'(timeout), 0);
    wait_done("e_latency", 3 * N);
`else
    chk("timeout_tied", int'(timeout), 0);
`endif
    step();
    chk("opq_left", opq.size(), 0);
    chk("finq_left", finq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
